// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; ADD/ADD1/SUB/SUB1/MUL in one cycle, ROOF/FLOOR/MOD via restoring divider.
// Latency: single-cycle ops, illegal ops and divide-by-zero complete at the accept edge; divides take WIDTH+1 edges.
// Backpressure: Start is only sampled while Busy=0; a Start seen while Busy=1 is dropped, not queued.
//
// Ports:
//   Clock, Reset_n       rising-edge clock, asynchronous active-low reset
//   Start, ALUOp         operation request and opcode (1 ADD .. 8 MOD, others illegal)
//   In_1, In_2           operands, captured at accept
//   Busy, Done           divider in progress / one-cycle completion pulse
//   ALUOut, Z, Y, E      registered result, zero, carry/borrow/overflow, error
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] In_1,
    input  logic [WIDTH-1:0] In_2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Z,
    output logic             Y,
    output logic             E
);

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_ADD1  = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_SUB1  = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_ROOF  = 4'd6;
    localparam logic [3:0] OP_FLOOR = 4'd7;
    localparam logic [3:0] OP_MOD   = 4'd8;

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // captured divide operation and divider datapath
    logic [3:0]       op_q;
    logic [WIDTH-1:0] quo;      // dividend shifts out MSB first, quotient shifts in LSB
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;      // partial remainder
    logic [CW-1:0]    cnt;

    logic             done_q;
    logic [WIDTH-1:0] out_q;
    logic             z_q, y_q, e_q;

    // next-state / control from the FSM process
    logic             load, iter, upd;
    logic             done_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             z_nxt, y_nxt, e_nxt;

    // single-cycle arithmetic, extended by one bit (or WIDTH bits) for carry/borrow/overflow
    logic [WIDTH:0]     sum, inc, diff, dec;
    logic [2*WIDTH-1:0] prod;

    assign sum  = {1'b0, In_1} + {1'b0, In_2};
    assign inc  = {1'b0, In_1} + {{WIDTH{1'b0}}, 1'b1};
    assign diff = {1'b0, In_1} - {1'b0, In_2};
    assign dec  = {1'b0, In_1} - {{WIDTH{1'b0}}, 1'b1};
    assign prod = {{WIDTH{1'b0}}, In_1} * {{WIDTH{1'b0}}, In_2};

    // one restoring step: shift in next dividend bit, trial-subtract, keep if non-negative.
    // The remainder is always below the divisor, so a negative trial shows up in bit WIDTH.
    logic [WIDTH:0] shifted, trial;
    logic           fits, rem_nz;

    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign fits    = ~trial[WIDTH];
    assign rem_nz  = |rem;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        iter      = 1'b0;
        upd       = 1'b0;
        done_nxt  = 1'b0;
        out_nxt   = out_q;
        z_nxt     = z_q;
        y_nxt     = y_q;
        e_nxt     = e_q;

        case (state)
            IDLE: begin
                if (Start) begin
                    done_nxt = 1'b1;
                    e_nxt    = 1'b0;
                    upd      = 1'b1;
                    case (ALUOp)
                        OP_ADD: begin
                            out_nxt = sum[WIDTH-1:0];
                            y_nxt   = sum[WIDTH];
                        end
                        OP_ADD1: begin
                            out_nxt = inc[WIDTH-1:0];
                            y_nxt   = inc[WIDTH];
                        end
                        OP_SUB: begin
                            out_nxt = diff[WIDTH-1:0];
                            y_nxt   = diff[WIDTH];
                        end
                        OP_SUB1: begin
                            out_nxt = dec[WIDTH-1:0];
                            y_nxt   = dec[WIDTH];
                        end
                        OP_MUL: begin
                            out_nxt = prod[WIDTH-1:0];
                            y_nxt   = |prod[2*WIDTH-1:WIDTH];
                        end
                        OP_ROOF, OP_FLOOR, OP_MOD: begin
                            if (In_2 == '0) begin
                                // divide by zero finishes at once with a saturated result
                                out_nxt = '1;
                                y_nxt   = 1'b0;
                                e_nxt   = 1'b1;
                            end else begin
                                done_nxt  = 1'b0;
                                upd       = 1'b0;
                                e_nxt     = e_q;
                                load      = 1'b1;
                                state_nxt = DIV;
                            end
                        end
                        default: begin
                            // illegal opcode: flag it, leave result/Z/Y untouched
                            upd   = 1'b0;
                            e_nxt = 1'b1;
                        end
                    endcase
                end
            end
            DIV: begin
                iter = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                upd       = 1'b1;
                y_nxt     = 1'b0;
                e_nxt     = 1'b0;
                case (op_q)
                    OP_FLOOR: out_nxt = quo;
                    OP_MOD:   out_nxt = rem[WIDTH-1:0];
                    default:  out_nxt = quo + {{(WIDTH-1){1'b0}}, rem_nz};
                endcase
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (upd) begin
            z_nxt = (out_nxt == '0);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            op_q <= '0;
            quo  <= '0;
            dvs  <= '0;
            rem  <= '0;
            cnt  <= '0;
        end else if (load) begin
            op_q <= ALUOp;
            quo  <= In_1;
            dvs  <= In_2;
            rem  <= '0;
            cnt  <= '0;
        end else if (iter) begin
            quo <= {quo[WIDTH-2:0], fits};
            rem <= fits ? trial : shifted;
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            done_q <= 1'b0;
            out_q  <= '0;
            z_q    <= 1'b0;
            y_q    <= 1'b0;
            e_q    <= 1'b0;
        end else begin
            done_q <= done_nxt;
            out_q  <= out_nxt;
            z_q    <= z_nxt;
            y_q    <= y_nxt;
            e_q    <= e_nxt;
        end
    end

    assign Busy   = (state != IDLE);
    assign Done   = done_q;
    assign ALUOut = out_q;
    assign Z      = z_q;
    assign Y      = y_q;
    assign E      = e_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: checks alu_seq at WIDTH=16 and WIDTH=8 against constant vectors and an arithmetic model.
// Latency: measured in edges after the accept edge (0 for single-cycle ops, WIDTH+1 for divides).
// Backpressure: exercises Start held high through a divide and back-to-back single-cycle starts.
module tb_alu_seq;

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_ADD1  = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_SUB1  = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_ROOF  = 4'd6;
    localparam logic [3:0] OP_FLOOR = 4'd7;
    localparam logic [3:0] OP_MOD   = 4'd8;

    logic        clk;
    logic        rst_n;
    logic        start16, start8;
    logic [3:0]  alu_op;
    logic [15:0] in_1, in_2;

    logic        d16_busy, d16_done, d16_z, d16_y, d16_e;
    logic [15:0] d16_out;
    logic        d8_busy, d8_done, d8_z, d8_y, d8_e;
    logic [7:0]  d8_out;

    alu_seq #(.WIDTH(16)) u_dut16 (
        .Clock(clk), .Reset_n(rst_n), .Start(start16), .ALUOp(alu_op),
        .In_1(in_1), .In_2(in_2), .Busy(d16_busy), .Done(d16_done),
        .ALUOut(d16_out), .Z(d16_z), .Y(d16_y), .E(d16_e)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .Clock(clk), .Reset_n(rst_n), .Start(start8), .ALUOp(alu_op),
        .In_1(in_1[7:0]), .In_2(in_2[7:0]), .Busy(d8_busy), .Done(d8_done),
        .ALUOut(d8_out), .Z(d8_z), .Y(d8_y), .E(d8_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // view of whichever instance is under test
    logic        cur_sel;
    logic        s_busy, s_done, s_z, s_y, s_e;
    logic [15:0] s_out;
    assign s_busy = cur_sel ? d8_busy : d16_busy;
    assign s_done = cur_sel ? d8_done : d16_done;
    assign s_z    = cur_sel ? d8_z    : d16_z;
    assign s_y    = cur_sel ? d8_y    : d16_y;
    assign s_e    = cur_sel ? d8_e    : d16_e;
    assign s_out  = cur_sel ? {8'h00, d8_out} : d16_out;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model state, one slot per instance (0: WIDTH=16, 1: WIDTH=8)
    longint m_out [2];
    bit     m_z   [2];
    bit     m_y   [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0;
            m_z[i]   = 0;
            m_y[i]   = 0;
        end
    endtask

    // result of one operation from the arithmetic definition; updates the held state
    task automatic model(input bit sel, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] eo, output bit ez,
                         output bit ey, output bit ee, output int elat);
        int     w;
        longint lim, aa, bb, r, q, rm;
        w    = sel ? 8 : 16;
        lim  = longint'(1) << w;
        aa   = longint'(a) % lim;
        bb   = longint'(b) % lim;
        ee   = 0;
        elat = 0;
        case (op)
            OP_ADD:  begin r = aa + bb; m_out[sel] = r % lim; m_y[sel] = (r >= lim); end
            OP_ADD1: begin r = aa + 1;  m_out[sel] = r % lim; m_y[sel] = (r >= lim); end
            OP_SUB:  begin m_out[sel] = (aa - bb + lim) % lim; m_y[sel] = (aa < bb); end
            OP_SUB1: begin m_out[sel] = (aa - 1 + lim) % lim;  m_y[sel] = (aa == 0); end
            OP_MUL:  begin r = aa * bb; m_out[sel] = r % lim; m_y[sel] = (r >= lim); end
            OP_ROOF, OP_FLOOR, OP_MOD: begin
                m_y[sel] = 0;
                if (bb == 0) begin
                    m_out[sel] = lim - 1;
                    ee = 1;
                end else begin
                    q  = aa / bb;
                    rm = aa % bb;
                    if (op == OP_FLOOR)    m_out[sel] = q;
                    else if (op == OP_MOD) m_out[sel] = rm;
                    else                   m_out[sel] = q + ((rm != 0) ? 1 : 0);
                    elat = w + 1;
                end
            end
            default: ee = 1;
        endcase
        if (!(ee == 1 && !(op >= OP_ROOF && op <= OP_MOD)))
            m_z[sel] = (m_out[sel] == 0);
        eo = m_out[sel][15:0];
        ez = m_z[sel];
        ey = m_y[sel];
    endtask

    // launch one op, wait for Done (bounded), compare result, flags, latency and Busy length
    task automatic run_op(input bit sel, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] eo, input bit ez,
                          input bit ey, input bit ee, input int elat, input string name);
        int lat;
        int busy_n;
        cur_sel = sel;
        alu_op  = op;
        in_1    = a;
        in_2    = b;
        if (sel) start8 = 1'b1;
        else     start16 = 1'b1;
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start16 = 1'b0;
        in_1    = 16'($urandom);
        in_2    = 16'($urandom);
        alu_op  = 4'($urandom);
        lat     = 0;
        busy_n  = 0;
        while (!s_done && lat < 60) begin
            if (s_busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " done"}, 32'(s_done), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(elat));
        check({name, " busy cycles"}, 32'(busy_n), 32'(elat));
        check({name, " ALUOut"}, 32'(s_out), 32'(eo));
        check({name, " Z"}, 32'(s_z), 32'(ez));
        check({name, " Y"}, 32'(s_y), 32'(ey));
        check({name, " E"}, 32'(s_e), 32'(ee));
        @(posedge clk);
        #1;
        check({name, " done pulse width"}, 32'(s_done), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eo;
        bit          ez;
        bit          ey;
        bit          ee;
        int          elat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [15:0] eo, eo2;
        bit          ez, ey, ee;
        int          elat, dones;
        logic [15:0] got;
        logic [3:0]  rop;
        logic [15:0] ra, rb;
        bit          rsel;

        vecs[0]  = '{OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0};
        vecs[1]  = '{OP_SUB,   16'h0003, 16'h0005, 16'hFFFE, 0, 1, 0, 0};
        vecs[2]  = '{OP_MUL,   16'h0100, 16'h0100, 16'h0000, 1, 1, 0, 0};
        vecs[3]  = '{OP_FLOOR, 16'd100,  16'd7,    16'd14,   0, 0, 0, 17};
        vecs[4]  = '{OP_MOD,   16'd100,  16'd7,    16'd2,    0, 0, 0, 17};
        vecs[5]  = '{OP_ROOF,  16'd100,  16'd7,    16'd15,   0, 0, 0, 17};
        vecs[6]  = '{OP_ROOF,  16'd98,   16'd7,    16'd14,   0, 0, 0, 17};
        vecs[7]  = '{OP_FLOOR, 16'd5,    16'd0,    16'hFFFF, 0, 0, 1, 0};
        vecs[8]  = '{OP_ADD1,  16'h1233, 16'h0000, 16'h1234, 0, 0, 0, 0};
        vecs[9]  = '{4'd0,     16'h0000, 16'h0000, 16'h1234, 0, 0, 1, 0};
        vecs[10] = '{4'd15,    16'hAAAA, 16'h0000, 16'h1234, 0, 0, 1, 0};
        vecs[11] = '{OP_ADD1,  16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0};
        vecs[12] = '{OP_SUB1,  16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0, 0};
        vecs[13] = '{OP_MOD,   16'd7,    16'd7,    16'h0000, 1, 0, 0, 17};
        vecs[14] = '{OP_ROOF,  16'hFFFF, 16'h0001, 16'hFFFF, 0, 0, 0, 17};
        vecs[15] = '{OP_SUB,   16'd5,    16'd3,    16'd2,    0, 0, 0, 0};
        vecs[16] = '{OP_MUL,   16'h00FF, 16'h0101, 16'hFFFF, 0, 0, 0, 0};

        cur_sel = 1'b0;
        rst_n   = 1'b0;
        start16 = 1'b0;
        start8  = 1'b0;
        alu_op  = 4'd0;
        in_1    = 16'd0;
        in_2    = 16'd0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset Busy", 32'(d16_busy), 32'd0);
        check("reset Done", 32'(d16_done), 32'd0);
        check("reset ALUOut", 32'(d16_out), 32'd0);
        check("reset Z", 32'(d16_z), 32'd0);
        check("reset Y", 32'(d16_y), 32'd0);
        check("reset E", 32'(d16_e), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // constant vectors
        foreach (vecs[i]) begin
            model(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, eo, ez, ey, ee, elat);
            run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].ez,
                   vecs[i].ey, vecs[i].ee, vecs[i].elat, $sformatf("vec%0d", i));
        end

        // back-to-back single-cycle ops: ADD then SUB1 on consecutive edges
        cur_sel = 1'b0;
        model(1'b0, OP_ADD, 16'h1000, 16'h0234, eo, ez, ey, ee, elat);
        model(1'b0, OP_SUB1, 16'h8000, 16'h0000, eo2, ez, ey, ee, elat);
        alu_op  = OP_ADD;
        in_1    = 16'h1000;
        in_2    = 16'h0234;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        check("b2b first Done", 32'(d16_done), 32'd1);
        check("b2b first ALUOut", 32'(d16_out), 32'(eo));
        alu_op = OP_SUB1;
        in_1   = 16'h8000;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        check("b2b second Done", 32'(d16_done), 32'd1);
        check("b2b second ALUOut", 32'(d16_out), 32'(eo2));
        check("b2b second Y", 32'(d16_y), 32'(ey));
        @(posedge clk);
        #1;
        check("b2b Done falls", 32'(d16_done), 32'd0);

        // reset in the middle of a ROOF 100/7
        alu_op  = OP_ROOF;
        in_1    = 16'd100;
        in_2    = 16'd7;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midreset busy before", 32'(d16_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset Busy", 32'(d16_busy), 32'd0);
        check("midreset ALUOut", 32'(d16_out), 32'd0);
        check("midreset Z", 32'(d16_z), 32'd0);
        check("midreset Y", 32'(d16_y), 32'd0);
        check("midreset E", 32'(d16_e), 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (d16_done) dones++;
        end
        check("midreset no Done", 32'(dones), 32'd0);

        // Start held through a ROOF with operands changed after accept
        model(1'b0, OP_ROOF, 16'd100, 16'd7, eo, ez, ey, ee, elat);
        alu_op  = OP_ROOF;
        in_1    = 16'd100;
        in_2    = 16'd7;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        in_1   = 16'h00FF;
        in_2   = 16'd3;
        alu_op = OP_ADD;
        dones  = 0;
        got    = 16'h0;
        for (int i = 0; i < 30; i++) begin
            if (d16_done) begin
                dones++;
                got     = d16_out;
                start16 = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start16 = 1'b0;
        check("held start Done count", 32'(dones), 32'd1);
        check("held start ALUOut", 32'(got), 32'(eo));

        // WIDTH=8 instance
        model(1'b1, OP_FLOOR, 16'd255, 16'd1, eo, ez, ey, ee, elat);
        run_op(1'b1, OP_FLOOR, 16'd255, 16'd1, 16'd255, 0, 0, 0, 9, "w8 floor 255/1");
        model(1'b1, OP_ROOF, 16'd255, 16'd2, eo, ez, ey, ee, elat);
        run_op(1'b1, OP_ROOF, 16'd255, 16'd2, 16'd128, 0, 0, 0, 9, "w8 roof 255/2");

        // randomized ops on both widths against the model
        for (int i = 0; i < 70; i++) begin
            rsel = 1'($urandom_range(0, 1));
            rop  = 4'($urandom_range(0, 9));
            ra   = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 7));
                default: rb = 16'($urandom);
            endcase
            if (rsel && rb[7:0] == 8'd0 && $urandom_range(0, 1) == 1) rb = rb | 16'd3;
            model(rsel, rop, ra, rb, eo, ez, ey, ee, elat);
            run_op(rsel, rop, ra, rb, eo, ez, ey, ee, elat,
                   $sformatf("rand%0d w%0d op%0d a=%0h b=%0h", i, rsel ? 8 : 16, rop, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
